// File: rtl/ioctl_mem_arb.sv
// ioctl_mem_arb: shares one byte-wide memory port between the data_io stream and core requests.
// Define IOCTL_INTERLEAVE_EN to give the core one access slot between ioctl bytes.
module ioctl_mem_arb #(
    parameter int ADDR_W = 25
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              ioctl_download,
    input  logic              ioctl_upload,
    input  logic              ioctl_wr,
    input  logic [ADDR_W-1:0] ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    output logic [7:0]        ioctl_din,
    output logic              clkref_n,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [7:0]        core_din,
    output logic [7:0]        core_dout,
    output logic              core_ack,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_din,
    input  logic [7:0]        mem_dout,
    input  logic              mem_ack,
    output logic              xfer_busy
);
    typedef enum logic [2:0] {IDLE, STROBE, GAP, IO_MEM, CORE_MEM} state_t;
    state_t state;
    logic   xfer, core_ok;
    assign xfer = ioctl_download | ioctl_upload;
`ifdef IOCTL_INTERLEAVE_EN
    logic turn;
    assign core_ok = core_req & (~xfer | turn);
    // the core earns a turn after every ioctl slot and gives it back once served
    always_ff @(posedge clk_sys or posedge reset)
        if (reset) turn <= 1'b0;
        else if (state == CORE_MEM && mem_ack) turn <= 1'b0;
        else if ((state == IO_MEM && mem_ack) || (state == GAP && !ioctl_upload && !ioctl_wr)) turn <= 1'b1;
`else
    assign core_ok = core_req & ~xfer;
`endif
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            clkref_n  <= 1'b1;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_din   <= '0;
            ioctl_din <= '0;
            core_ack  <= 1'b0;
            core_dout <= '0;
            xfer_busy <= 1'b0;
        end else begin
            core_ack  <= 1'b0;
            clkref_n  <= 1'b1;
            xfer_busy <= xfer | (state == GAP && (ioctl_upload || ioctl_wr)) | (state == IO_MEM && !mem_ack);
            case (state)
                IDLE:
                    if (core_ok) begin
                        state    <= CORE_MEM;
                        mem_req  <= 1'b1;
                        mem_we   <= core_we;
                        mem_addr <= core_addr;
                        mem_din  <= core_din;
                    end else if (xfer) begin
                        state    <= STROBE;
                        clkref_n <= 1'b0;
                    end
                STROBE: state <= GAP;
                GAP:
                    if (ioctl_upload) begin
                        state    <= IO_MEM;
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= ioctl_addr;
                    end else if (ioctl_wr) begin
                        state    <= IO_MEM;
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b1;
                        mem_addr <= ioctl_addr;
                        mem_din  <= ioctl_dout;
                    end else state <= IDLE;
                IO_MEM:
                    if (mem_ack) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        if (!mem_we) ioctl_din <= mem_dout;
                    end
                CORE_MEM:
                    if (mem_ack) begin
                        state    <= IDLE;
                        mem_req  <= 1'b0;
                        mem_we   <= 1'b0;
                        core_ack <= 1'b1;
                        if (!mem_we) core_dout <= mem_dout;
                    end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
